// File: rtl/apb_regfile_slave.sv
// APB slave with a byte-strobed register file, a read-only ID word at index 0,
// address-range error reporting and per-transfer programmable wait states.
module apb_regfile_slave #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h10,
    parameter int                WAIT_W    = 8,
    parameter logic [DATA_W-1:0] ID_VALUE  = 'hA5
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    input  logic [WAIT_W-1:0]     wait_count,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [1:0]            out_state,
    output logic [WAIT_W-1:0]     wait_left
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_SETUP  = 2'b01;
    localparam logic [1:0] S_WAIT   = 2'b10;
    localparam logic [1:0] S_ACCESS = 2'b11;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_strb;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic [ADDR_W:0]   w_diff;
    logic              w_borrow;
    logic [ADDR_W-1:0] w_index;
    logic [IDX_W-1:0]  w_ridx;
    logic              w_err;

    // The extra top bit of the subtraction is the borrow: paddr below the window.
    assign w_diff   = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_borrow = w_diff[ADDR_W];
    assign w_index  = w_diff[ADDR_W-1:0];
    assign w_ridx   = w_index[IDX_W-1:0];
    assign w_err    = w_borrow | ({1'b0, w_index} >= DEPTH_X) | (r_write && (w_index == '0));

    assign out_state = r_state;

    always_ff @(posedge pclk) begin
        if (!preset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            prdata    <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            wait_left <= '0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        r_state   <= S_SETUP;
                        r_addr    <= paddr;
                        r_write   <= pwrite;
                        r_wdata   <= pwdata;
                        r_strb    <= pstrb;
                        wait_left <= wait_count;
                    end
                end
                S_SETUP, S_WAIT: begin
                    // penable is deliberately not checked here; a dropped psel aborts.
                    if (!psel) begin
                        r_state   <= S_IDLE;
                        wait_left <= '0;
                    end else if (wait_left == '0) begin
                        r_state <= S_ACCESS;
                        pready  <= 1'b1;
                        pslverr <= w_err;
                        if (!r_write) begin
                            prdata <= w_err ? '0 : ((w_index == '0) ? ID_VALUE : r_regs[w_ridx]);
                        end else if (!w_err) begin
                            for (int b = 0; b < STRB_W; b++)
                                if (r_strb[b]) r_regs[w_ridx][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end else begin
                        r_state   <= S_WAIT;
                        wait_left <= wait_left - WAIT_W'(1);
                    end
                end
                S_ACCESS: begin
                    r_state <= S_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
